// File: rtl/mm_pkg.sv
// Shared types and arithmetic helpers for the sequential matrix multiplier.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Working width for the conversion helper; accumulators up to this width are supported.
  localparam int WIDE = 64;

  typedef struct packed {
    logic [WIDE-1:0] res;  // converted value, meaningful in the low BITS bits
    logic            chg;  // conversion altered the value (clamped or truncated)
  } conv_t;

  // Accumulator width that can hold N full-width products without wrapping.
  function automatic int acc_width(input int bits, input int n);
    return 2 * bits + $clog2(n);
  endfunction

  // Reduce a full-width sum (already sign/zero extended to WIDE) to a BITS-wide element.
  // The change flag compares the re-extended low bits against the original sum, which
  // is exactly the condition under which either clamping or truncation alters the value.
  function automatic conv_t sat_trunc(input logic [WIDE-1:0] value, input int bits,
                                      input bit is_signed, input bit saturate);
    logic [WIDE-1:0]        mask;
    logic [WIDE-1:0]        sbit;
    logic [WIDE-1:0]        trunc;
    logic [WIDE-1:0]        back;
    logic signed [WIDE-1:0] sval;
    logic signed [WIDE-1:0] smax;
    logic signed [WIDE-1:0] smin;
    conv_t                  r;
    mask  = (64'd1 << bits) - 64'd1;
    sbit  = 64'd1 << (bits - 1);
    trunc = value & mask;
    // (t ^ s) - s sign-extends t from its top bit s
    back  = is_signed ? ((trunc ^ sbit) - sbit) : trunc;
    sval  = $signed(value);
    smax  = $signed(sbit - 64'd1);
    smin  = $signed(64'd0 - sbit);
    r.chg = (back != value);
    r.res = trunc;
    if (saturate) begin
      if (is_signed) begin
        if (sval > smax)      r.res = smax;
        else if (sval < smin) r.res = smin;
      end else if (value > mask) begin
        r.res = mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Single multiply-accumulate: combinational product plus a registered accumulator.
// Latency: next_sum is combinational from a/b/acc; acc updates one cycle after en.
// Backpressure: none; the controller decides every cycle via en/clr.
module mm_mac #(
  parameter int BITS     = 8,
  parameter int ACC_BITS = 19,
  parameter int SIGNED   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     a,
  input  logic [BITS-1:0]     b,
  input  logic                en,
  input  logic                clr,
  output logic [ACC_BITS-1:0] next_sum
);

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] prod_ext;

  if (SIGNED != 0) begin : g_signed
    logic signed [2*BITS-1:0] prod;
    assign prod     = $signed({{BITS{a[BITS-1]}}, a}) * $signed({{BITS{b[BITS-1]}}, b});
    assign prod_ext = ACC_BITS'(prod);
  end else begin : g_unsigned
    logic [2*BITS-1:0] prod;
    assign prod     = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
    assign prod_ext = ACC_BITS'(prod);
  end

  assign next_sum = acc + prod_ext;

  // Accumulate one product per enabled cycle; clear takes priority so a dot product can restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= next_sum;
  end

endmodule

// File: rtl/seq_matrix_mult.sv
// Sequential N x N matrix multiplier C = A x B using one MAC and a start/busy/done handshake.
// Latency: N^3 RUN cycles after start is accepted, done on the following cycle (N^3+2 per matrix).
// Backpressure: none; start while busy or during done is dropped, there is no queueing.
module seq_matrix_mult
  import mm_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int N        = 8,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int ACC_BITS = acc_width(BITS, N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*N*BITS-1:0] A,
  input  logic [N*N*BITS-1:0] B,
  output logic [N*N*BITS-1:0] C,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int            IW   = $clog2(N);
  localparam int            VW   = N * N * BITS;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t              state;
  logic [IW-1:0]       i;
  logic [IW-1:0]       j;
  logic [IW-1:0]       k;
  logic [VW-1:0]       a_q;
  logic [VW-1:0]       b_q;
  logic [VW-1:0]       work_q;
  logic [VW-1:0]       c_next;
  logic                ovf_work;
  logic [BITS-1:0]     a_el;
  logic [BITS-1:0]     b_el;
  logic                mac_en;
  logic                mac_clr;
  logic [ACC_BITS-1:0] next_sum;
  logic [WIDE-1:0]     sum_wide;
  conv_t               conv;
  logic                k_last;
  logic                step_last;
  logic                unused_conv_hi;

  assign a_el      = a_q[(N*i + k)*BITS +: BITS];
  assign b_el      = b_q[(N*k + j)*BITS +: BITS];
  assign k_last    = (k == LAST);
  assign step_last = k_last && (j == LAST) && (i == LAST);
  assign mac_en    = (state == RUN);
  // Clearing on accept means the first RUN cycle starts from an empty accumulator.
  assign mac_clr   = ((state == IDLE) && start) || ((state == RUN) && k_last);

  mm_mac #(
    .BITS    (BITS),
    .ACC_BITS(ACC_BITS),
    .SIGNED  (SIGNED)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_el),
    .b       (b_el),
    .en      (mac_en),
    .clr     (mac_clr),
    .next_sum(next_sum)
  );

  // Extend the completed dot product, convert it, and form the result image with the final element bypassed.
  always_comb begin
    if (SIGNED != 0) sum_wide = WIDE'($signed(next_sum));
    else             sum_wide = WIDE'(next_sum);
    conv   = sat_trunc(sum_wide, BITS, SIGNED != 0, SATURATE != 0);
    c_next = work_q;
    c_next[VW-1 -: BITS] = conv.res[BITS-1:0];
  end

  assign unused_conv_hi = ^conv.res[WIDE-1:BITS];

  // Controller: operand latch, i/j/k sweep, write-back and the registered handshake outputs.
  // C/ovf/done load on the edge into DONE so they are valid in the done cycle itself; the
  // (N-1,N-1) element is still in flight on that edge, hence the bypass in c_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      ovf_work <= 1'b0;
      C        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            ovf_work <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (k_last) begin
            work_q[(N*i + j)*BITS +: BITS] <= conv.res[BITS-1:0];
            ovf_work <= ovf_work | conv.chg;
            k        <= '0;
            if (j == LAST) begin
              j <= '0;
              i <= (i == LAST) ? '0 : i + IW'(1);
            end else begin
              j <= j + IW'(1);
            end
            if (step_last) begin
              C     <= c_next;
              ovf   <= ovf_work | conv.chg;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            k <= k + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_matrix_mult.sv
// Bench for seq_matrix_mult: four configurations, a per-cycle reference model and directed literals.
// Latency: model predicts busy/done/C/ovf cycle by cycle from start acceptance.
// Backpressure: checks that start while busy or during done is dropped.
module tb_seq_matrix_mult;

  typedef struct packed {
    logic [511:0] c;
    logic         o;
  } res_t;

  localparam int NN[4] = '{2, 2, 2, 8};
  localparam bit SG[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit SA[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start[4];
  logic [31:0]  a2[3];
  logic [31:0]  b2[3];
  logic [31:0]  c2[3];
  logic [511:0] a8;
  logic [511:0] b8;
  logic [511:0] c8;
  logic         busy_o[4];
  logic         done_o[4];
  logic         ovf_o[4];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;
  int done_cnt[4];
  int last_done[4];

  // model state
  logic m_busy[4];
  int   m_cnt[4];
  res_t m_pr[4];
  res_t m_res[4];

  initial forever #5 clk = ~clk;

  seq_matrix_mult #(.BITS(8), .N(2), .SIGNED(0), .SATURATE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .A(a2[0]), .B(b2[0]), .C(c2[0]),
    .busy(busy_o[0]), .done(done_o[0]), .ovf(ovf_o[0]));
  seq_matrix_mult #(.BITS(8), .N(2), .SIGNED(0), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .A(a2[1]), .B(b2[1]), .C(c2[1]),
    .busy(busy_o[1]), .done(done_o[1]), .ovf(ovf_o[1]));
  seq_matrix_mult #(.BITS(8), .N(2), .SIGNED(1), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .A(a2[2]), .B(b2[2]), .C(c2[2]),
    .busy(busy_o[2]), .done(done_o[2]), .ovf(ovf_o[2]));
  seq_matrix_mult #(.BITS(8), .N(8), .SIGNED(0), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .A(a8), .B(b8), .C(c8),
    .busy(busy_o[3]), .done(done_o[3]), .ovf(ovf_o[3]));

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [511:0] in_a(input int x);
    if (x == 3) return a8;
    return {480'b0, a2[x]};
  endfunction

  function automatic logic [511:0] in_b(input int x);
    if (x == 3) return b8;
    return {480'b0, b2[x]};
  endfunction

  function automatic logic [511:0] out_c(input int x);
    if (x == 3) return c8;
    return {480'b0, c2[x]};
  endfunction

  function automatic longint elem(input logic [7:0] e, input bit sgn);
    if (sgn) return longint'($signed(e));
    return longint'(e);
  endfunction

  // Plain matrix product with range check and clamp/wrap to 8 bits.
  function automatic res_t mm_model(input logic [511:0] a, input logic [511:0] b,
                                    input int n, input bit sgn, input bit sat);
    res_t   r;
    longint s;
    longint lo;
    longint hi;
    longint v;
    r.c = '0;
    r.o = 1'b0;
    lo  = sgn ? -128 : 0;
    hi  = sgn ? 127 : 255;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++)
          s += elem(a[(n*i+k)*8 +: 8], sgn) * elem(b[(n*k+j)*8 +: 8], sgn);
        if (s < lo || s > hi) r.o = 1'b1;
        v = s;
        if (sat && s < lo) v = lo;
        if (sat && s > hi) v = hi;
        r.c[(n*i+j)*8 +: 8] = v[7:0];
      end
    end
    return r;
  endfunction

  // Reference timeline: accept in idle, busy for n^3+1 cycles, results appear in the done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < 4; x++) begin
        m_busy[x] <= 1'b0;
        m_cnt[x]  <= 0;
        m_pr[x]   <= '0;
        m_res[x]  <= '0;
      end
    end else begin
      for (int x = 0; x < 4; x++) begin
        if (!m_busy[x]) begin
          if (start[x]) begin
            m_pr[x]   <= mm_model(in_a(x), in_b(x), NN[x], SG[x], SA[x]);
            m_busy[x] <= 1'b1;
            m_cnt[x]  <= 0;
          end
        end else begin
          m_cnt[x] <= m_cnt[x] + 1;
          if (m_cnt[x] + 1 == NN[x] ** 3) m_res[x] <= m_pr[x];
          if (m_cnt[x] + 1 > NN[x] ** 3)  m_busy[x] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare every output of every instance against the model each cycle.
  initial begin
    for (int x = 0; x < 4; x++) begin
      done_cnt[x]  = 0;
      last_done[x] = 0;
    end
    forever begin
      @(negedge clk);
      for (int x = 0; x < 4; x++) begin
        if (done_o[x] === 1'b1) begin
          done_cnt[x]++;
          last_done[x] = cyc_cnt;
        end
        if (chk_en) begin
          chk($sformatf("u%0d busy", x), 512'(busy_o[x]), 512'(m_busy[x]));
          chk($sformatf("u%0d done", x), 512'(done_o[x]),
              512'(m_busy[x] && (m_cnt[x] == NN[x] ** 3)));
          chk($sformatf("u%0d ovf", x), 512'(ovf_o[x]), 512'(m_res[x].o));
          chk($sformatf("u%0d C", x), out_c(x), m_res[x].c);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start high for one edge; s is the counter value right after that edge.
  task automatic pulse_start(input int x, output int s);
    start[x] = 1'b1;
    @(posedge clk);
    #1;
    start[x] = 1'b0;
    s = cyc_cnt;
  endtask

  // Returns the done cycle number (cycle 1 = first cycle after acceptance) and busy cycles seen.
  task automatic wait_done(input int x, input int s, input int limit, output int dcyc, output int bcnt);
    dcyc = -1;
    bcnt = 0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (busy_o[x] === 1'b1) bcnt++;
      if (done_o[x] === 1'b1) begin
        dcyc = cyc_cnt - s + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d done timeout: got none expected pulse within %0d cycles", x, limit);
    end
  endtask

  task automatic load_ident_idx(input bit reverse);
    a8 = '0;
    b8 = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        if (i == j) a8[(8*i+j)*8 +: 8] = 8'd1;
        b8[(8*i+j)*8 +: 8] = reverse ? 8'(63 - (8*i+j)) : 8'(8*i+j);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    int bc;
    int dc0;
    logic [511:0] saved;
    for (int x = 0; x < 4; x++) start[x] = 1'b0;
    for (int x = 0; x < 3; x++) begin
      a2[x] = '0;
      b2[x] = '0;
    end
    a8 = '0;
    b8 = '0;

    #3 rst_n = 1'b0;
    step(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int x = 0; x < 4; x++) begin
      chk($sformatf("reset u%0d busy", x), 512'(busy_o[x]), 512'd0);
      chk($sformatf("reset u%0d done", x), 512'(done_o[x]), 512'd0);
      chk($sformatf("reset u%0d ovf", x), 512'(ovf_o[x]), 512'd0);
      chk($sformatf("reset u%0d C", x), out_c(x), 512'd0);
    end
    step(1);

    // basic unsigned product
    a2[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    b2[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    pulse_start(0, s);
    wait_done(0, s, 40, d, bc);
    chk("t1 done cycle", 512'(d), 512'd9);
    chk("t1 busy cycles", 512'(bc), 512'd9);
    chk("t1 C", 512'(c2[0]), 512'h322B1613);
    chk("t1 ovf", 512'(ovf_o[0]), 512'd0);
    chk("t1 model pin", 512'(m_res[0].c[31:0]), 512'h322B1613);

    // all-255 saturate and truncate
    a2[0] = '1; b2[0] = '1; a2[1] = '1; b2[1] = '1;
    pulse_start(0, s);
    wait_done(0, s, 40, d, bc);
    chk("t2 sat C", 512'(c2[0]), 512'hFFFFFFFF);
    chk("t2 sat ovf", 512'(ovf_o[0]), 512'd1);
    pulse_start(1, s);
    wait_done(1, s, 40, d, bc);
    chk("t2 trunc C", 512'(c2[1]), 512'h02020202);
    chk("t2 trunc ovf", 512'(ovf_o[1]), 512'd1);

    // signed identity and signed saturation
    a2[2] = {8'hFC, 8'h03, 8'h02, 8'hFF};
    b2[2] = {8'h01, 8'h00, 8'h00, 8'h01};
    pulse_start(2, s);
    wait_done(2, s, 40, d, bc);
    chk("t3 ident C", 512'(c2[2]), 512'hFC0302FF);
    chk("t3 ident ovf", 512'(ovf_o[2]), 512'd0);
    a2[2] = {4{8'h80}};
    b2[2] = {4{8'h80}};
    pulse_start(2, s);
    wait_done(2, s, 40, d, bc);
    chk("t3 neg sat C", 512'(c2[2]), 512'h7F7F7F7F);
    chk("t3 neg sat ovf", 512'(ovf_o[2]), 512'd1);

    // N=8 identity, operands scrambled mid-run
    load_ident_idx(1'b0);
    saved = b8;
    pulse_start(3, s);
    step(100);
    for (int w = 0; w < 16; w++) begin
      a8[w*32 +: 32] = $urandom();
      b8[w*32 +: 32] = $urandom();
    end
    wait_done(3, s, 600, d, bc);
    chk("t4 done cycle", 512'(d), 512'd513);
    chk("t4 C", c8, saved);
    chk("t4 ovf", 512'(ovf_o[3]), 512'd0);

    // extra starts at cycle 3 and at the done cycle are dropped
    load_ident_idx(1'b1);
    dc0 = done_cnt[3];
    pulse_start(3, s);
    step(1);
    start[3] = 1'b1;
    step(1);
    start[3] = 1'b0;
    chk("t5 C held mid-run", c8, saved);
    while (cyc_cnt - s + 1 < 513) step(1);
    start[3] = 1'b1;
    step(1);
    start[3] = 1'b0;
    step(30);
    chk("t5 done count", 512'(done_cnt[3] - dc0), 512'd1);
    chk("t5 done cycle", 512'(last_done[3] - s + 1), 512'd513);
    chk("t5 busy after", 512'(busy_o[3]), 512'd0);
    chk("t5 C", c8, {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                     8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19,
                     8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
                     8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39,
                     8'd40, 8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 8'd47, 8'd48, 8'd49,
                     8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57, 8'd58, 8'd59,
                     8'd60, 8'd61, 8'd62, 8'd63});

    // reset in cycle 4 of a run aborts it
    a2[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    b2[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    pulse_start(0, s);
    step(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6 C after reset", 512'(c2[0]), 512'd0);
    chk("t6 busy after reset", 512'(busy_o[0]), 512'd0);
    chk("t6 N8 C after reset", c8, 512'd0);
    step(2);
    rst_n = 1'b1;
    dc0 = done_cnt[0];
    step(20);
    chk("t6 no done", 512'(done_cnt[0] - dc0), 512'd0);
    pulse_start(0, s);
    wait_done(0, s, 40, d, bc);
    chk("t6 rerun done cycle", 512'(d), 512'd9);
    chk("t6 rerun C", 512'(c2[0]), 512'h322B1613);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
